alu_fp32: RTL and testbench
===========================

# alu_fp32

Single-cycle-issue, registered 32-bit arithmetic/logic unit with IEEE-754 single-precision add, subtract and multiply, used as the execute stage of the small register-file processor. Two 32-bit operands and a 5-bit opcode are sampled every rising clock edge, and the result appears on a 64-bit registered output one cycle later. Floating-point opcodes serve the series-evaluation programs (e.g. the cosine Taylor series); integer opcodes serve general datapath use.

## Interface
- No parameters; widths fixed at 32-bit operands and 64-bit result.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- a  in  32  operand A (integer or fp32 bit pattern)
- b  in  32  operand B
- opcode  in  5  operation select
- out  out  64  registered result; fp results in [31:0], [63:32] zero

## Operation
- Opcode map:
  - 00000 ADD: a+b, 32-bit wrap, zero-extended.
  - 00001 SUB: a−b, 32-bit wrap, zero-extended.
  - 00010 AND, 00011 OR, 00100 XOR: bitwise, zero-extended.
  - 00101 FADD: a+b, fp32.
  - 00110 FSUB: a−b, fp32 (FADD with sign of b inverted).
  - 00111 FMUL: a×b, fp32.
  - 01000 MUL: unsigned 32×32 → full 64-bit product.
  - 01001 SLT: signed a<b → 1 else 0.
  - 01010 SLL, 01011 SRL: a shifted by b[4:0], zero-extended.
  - All other codes: out = 0.
- FP rules (all FP opcodes):
  - Denormal inputs are treated as signed zero.
  - A zero operand gives the exact result: x+0=x; x×0 = zero with sign a.sign XOR b.sign.
  - Exact cancellation in add gives +0.
  - Mantissas are aligned with guard/round/sticky bits; results round to nearest, ties to even.
  - Exponent overflow gives signed infinity (exp 255, mantissa 0).
  - Exponent underflow (biased exp ≤ 0 after normalisation) gives signed zero.
  - Any NaN input gives canonical quiet NaN 32'h7FC00000.
  - Inf inputs: Inf±finite = Inf. Inf−Inf and Inf×0 give canonical NaN.
- No flags output. Results are purely a function of the sampled a, b and opcode.

## Timing
- While rst is high: out = 64'h0, asynchronously and immediately.
- On the first rising edge after rst deasserts, the inputs present are sampled.
- Latency: 1 cycle. out updates on the rising edge that samples the inputs and holds until the next edge.
- Full throughput: a new operation on every edge. There is no handshake and no stall.
- Back-to-back identical inputs produce the same out value; no toggling.
- If rst asserts mid-operation, the in-flight result is discarded and out is 0.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD … OP_SRL, OP_FADD, OP_FSUB, OP_FMUL);
  - fp32 field constants: EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000.
- One natural sub-module, fp32_addsub: combinational align/add/normalise/round.
- FMUL stays inline: a 24×24 mantissa product plus the shared rounding function from alu_pkg.
- Top level: combinational result mux feeding a single 64-bit output register with async reset.

## Test plan
- Reset: hold rst with a=32'h3F800000, b=32'h3F800000, opcode=00111 → out stays 0. Release rst → next edge out=64'h3F800000 (1.0×1.0).
- FMUL: a=32'h3F800000 (1.0), b=32'hBF000000 (−0.5) → 64'h00000000BF000000. a=32'h40000000, b=32'h40400000 → 32'h40C00000 (6.0).
- FADD/FSUB:
  - 1.0 + (−0.5) → 32'h3F000000.
  - FSUB 1.0−1.0 → 32'h00000000.
  - FSUB 32'h3F800000 − 32'h3D2AAAAB → correctly rounded 32'h3F755555.
- FP specials:
  - FMUL 32'h7F000000×32'h40000000 → 32'h7F800000.
  - FADD 32'h7F800000 + 32'hFF800000 → 32'h7FC00000.
  - FMUL with denormal 32'h00000001 × 2.0 → 0.
- Integer ops:
  - ADD 32'hFFFFFFFF+1 → 0.
  - MUL 32'hFFFFFFFF×32'hFFFFFFFF → 64'hFFFFFFFE00000001.
  - SLT −1<0 → 1.
  - SLL 1 by 31 → 32'h80000000.
  - Unused opcode 11111 → 0.
- Throughput: change opcode each cycle (ADD, FMUL, XOR) → each result appears exactly one edge later, in order. Assert rst mid-stream → out is 0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map, fp32 field constants and the fp32 round-and-pack helper
// used by both the add/subtract path and the multiplier.
package alu_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_AND  = 5'b00010;
   localparam logic [4:0] OP_OR   = 5'b00011;
   localparam logic [4:0] OP_XOR  = 5'b00100;
   localparam logic [4:0] OP_FADD = 5'b00101;
   localparam logic [4:0] OP_FSUB = 5'b00110;
   localparam logic [4:0] OP_FMUL = 5'b00111;
   localparam logic [4:0] OP_MUL  = 5'b01000;
   localparam logic [4:0] OP_SLT  = 5'b01001;
   localparam logic [4:0] OP_SLL  = 5'b01010;
   localparam logic [4:0] OP_SRL  = 5'b01011;

   localparam logic [9:0]  EXP_BIAS = 10'd127;
   localparam logic [7:0]  EXP_MAX  = 8'd255;
   localparam logic [31:0] QNAN     = 32'h7FC00000;

   // man = {hidden, 23 fraction, guard, round, sticky}; round to nearest even,
   // then saturate to infinity or flush to zero on exponent range.
   function automatic logic [31:0] fp_round_pack(input logic sign,
                                                 input logic signed [9:0] exp,
                                                 input logic [26:0] man);
      logic                inc_s;
      logic [24:0]         rm_s;
      logic signed [9:0]   e_s;
      logic [31:0]         r_s;
      inc_s = man[2] & (man[1] | man[0] | man[3]);
      rm_s  = {1'b0, man[26:3]} + {24'd0, inc_s};
      if (rm_s[24]) begin
         e_s  = exp + 10'sd1;
         rm_s = rm_s >> 1;
      end else begin
         e_s  = exp;
      end
      if (e_s >= 10'sd255) begin
         r_s = {sign, EXP_MAX, 23'd0};
      end else if (e_s <= 10'sd0) begin
         r_s = {sign, 31'd0};
      end else begin
         r_s = {sign, e_s[7:0], rm_s[22:0]};
      end
      return r_s;
   endfunction

endpackage

// File: rtl/fp32_addsub.sv
// Combinational fp32 adder: align with guard/round/sticky, add or subtract
// magnitudes, normalise, round. Subtraction is done by the caller flipping b's sign.
module fp32_addsub
   import alu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   logic        za_s, zb_s, nan_a_s, nan_b_s, inf_a_s, inf_b_s, a_big_s;
   logic        big_sg_s, sml_sg_s;
   logic [7:0]  big_e_s, sml_e_s, ediff_s;
   logic [23:0] big_m_s, sml_m_s;
   logic [49:0] shifted_s;
   logic [26:0] aligned_s, norm_s;
   logic [27:0] sum_s;
   logic [4:0]  lz_s;
   logic signed [9:0] ne_s;

   assign za_s    = (a[30:23] == 8'd0);
   assign zb_s    = (b[30:23] == 8'd0);
   assign nan_a_s = (a[30:23] == EXP_MAX) && (a[22:0] != 23'd0);
   assign nan_b_s = (b[30:23] == EXP_MAX) && (b[22:0] != 23'd0);
   assign inf_a_s = (a[30:23] == EXP_MAX) && (a[22:0] == 23'd0);
   assign inf_b_s = (b[30:23] == EXP_MAX) && (b[22:0] == 23'd0);
   assign a_big_s = (a[30:0] >= b[30:0]);

   // Order by magnitude, align the smaller operand, add and normalise.
   always_comb begin
      big_sg_s = a_big_s ? a[31] : b[31];
      sml_sg_s = a_big_s ? b[31] : a[31];
      big_e_s  = a_big_s ? a[30:23] : b[30:23];
      sml_e_s  = a_big_s ? b[30:23] : a[30:23];
      big_m_s  = {1'b1, (a_big_s ? a[22:0] : b[22:0])};
      sml_m_s  = {1'b1, (a_big_s ? b[22:0] : a[22:0])};
      ediff_s  = big_e_s - sml_e_s;
      shifted_s = {sml_m_s, 26'd0} >> ediff_s;
      // Beyond 26 places the whole smaller mantissa collapses into sticky.
      aligned_s = (ediff_s > 8'd26) ? 27'd1 : {shifted_s[49:24], |shifted_s[23:0]};
      if (big_sg_s == sml_sg_s) begin
         sum_s = {1'b0, big_m_s, 3'b000} + {1'b0, aligned_s};
      end else begin
         sum_s = {1'b0, big_m_s, 3'b000} - {1'b0, aligned_s};
      end
      lz_s = 5'd0;
      for (int i = 0; i <= 26; i++) begin
         if (sum_s[i]) begin
            lz_s = 5'(26 - i);
         end else begin
            lz_s = lz_s;
         end
      end
      if (sum_s[27]) begin
         norm_s = {sum_s[27:2], sum_s[1] | sum_s[0]};
         ne_s   = $signed({2'b00, big_e_s}) + 10'sd1;
      end else begin
         norm_s = sum_s[26:0] << lz_s;
         ne_s   = $signed({2'b00, big_e_s}) - $signed({5'd0, lz_s});
      end
   end

   // Special operands take priority over the arithmetic path.
   always_comb begin
      if (nan_a_s || nan_b_s) begin
         y = QNAN;
      end else if (inf_a_s && inf_b_s) begin
         y = (a[31] != b[31]) ? QNAN : {a[31], EXP_MAX, 23'd0};
      end else if (inf_a_s) begin
         y = {a[31], EXP_MAX, 23'd0};
      end else if (inf_b_s) begin
         y = {b[31], EXP_MAX, 23'd0};
      end else if (za_s && zb_s) begin
         y = {a[31] & b[31], 31'd0};
      end else if (za_s) begin
         y = b;
      end else if (zb_s) begin
         y = a;
      end else if (sum_s == 28'd0) begin
         y = 32'd0;
      end else begin
         y = fp_round_pack(big_sg_s, ne_s, norm_s);
      end
   end

endmodule

// File: rtl/alu_fp32.sv
// Execute-stage ALU: integer and fp32 operations selected by opcode, result
// registered into a 64-bit output with one cycle of latency.
module alu_fp32
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  opcode,
   output logic [63:0] out
);

   logic [31:0] addsub_b_s, addsub_y_s, fmul_y_s;
   logic [63:0] result_s;
   logic [23:0] ma_s, mb_s;
   logic [47:0] prod_s;
   logic [26:0] mman_s;
   logic signed [9:0] mexp_s;
   logic        msign_s, za_s, zb_s, nan_s, inf_a_s, inf_b_s;

   assign addsub_b_s = (opcode == OP_FSUB) ? {~b[31], b[30:0]} : b;

   fp32_addsub u_addsub (
      .a (a),
      .b (addsub_b_s),
      .y (addsub_y_s)
   );

   // Inline fp32 multiply: 24x24 product, normalise by at most one place, round.
   always_comb begin
      za_s    = (a[30:23] == 8'd0);
      zb_s    = (b[30:23] == 8'd0);
      nan_s   = ((a[30:23] == EXP_MAX) && (a[22:0] != 23'd0)) ||
                ((b[30:23] == EXP_MAX) && (b[22:0] != 23'd0));
      inf_a_s = (a[30:23] == EXP_MAX) && (a[22:0] == 23'd0);
      inf_b_s = (b[30:23] == EXP_MAX) && (b[22:0] == 23'd0);
      msign_s = a[31] ^ b[31];
      ma_s    = {1'b1, a[22:0]};
      mb_s    = {1'b1, b[22:0]};
      prod_s  = ma_s * mb_s;
      mexp_s  = $signed({2'b00, a[30:23]} + {2'b00, b[30:23]} + {9'd0, prod_s[47]} - EXP_BIAS);
      if (prod_s[47]) begin
         mman_s = {prod_s[47:24], prod_s[23], prod_s[22], |prod_s[21:0]};
      end else begin
         mman_s = {prod_s[46:23], prod_s[22], prod_s[21], |prod_s[20:0]};
      end
      if (nan_s || (inf_a_s && zb_s) || (inf_b_s && za_s)) begin
         fmul_y_s = QNAN;
      end else if (inf_a_s || inf_b_s) begin
         fmul_y_s = {msign_s, EXP_MAX, 23'd0};
      end else if (za_s || zb_s) begin
         fmul_y_s = {msign_s, 31'd0};
      end else begin
         fmul_y_s = fp_round_pack(msign_s, mexp_s, mman_s);
      end
   end

   // Result select; unused opcodes yield zero.
   always_comb begin
      case (opcode)
         OP_ADD:  result_s = {32'd0, a + b};
         OP_SUB:  result_s = {32'd0, a - b};
         OP_AND:  result_s = {32'd0, a & b};
         OP_OR:   result_s = {32'd0, a | b};
         OP_XOR:  result_s = {32'd0, a ^ b};
         OP_FADD: result_s = {32'd0, addsub_y_s};
         OP_FSUB: result_s = {32'd0, addsub_y_s};
         OP_FMUL: result_s = {32'd0, fmul_y_s};
         OP_MUL:  result_s = {32'd0, a} * {32'd0, b};
         OP_SLT:  result_s = {63'd0, ($signed(a) < $signed(b))};
         OP_SLL:  result_s = {32'd0, a << b[4:0]};
         OP_SRL:  result_s = {32'd0, a >> b[4:0]};
         default: result_s = 64'd0;
      endcase
   end

   // Output register, cleared asynchronously by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out <= 64'd0;
      end else begin
         out <= result_s;
      end
   end

endmodule

// File: tb/tb_alu_fp32.sv
// Scoreboard bench for alu_fp32: expected values queued at issue and compared
// one edge later; fp cases use fixed vectors, integer cases a small model.
module tb_alu_fp32;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a, b;
   logic [4:0]  opcode;
   logic [63:0] out;

   int errors = 0;
   int checks = 0;
   logic [63:0] sb_q[$];
   string       tag_q[$];

   alu_fp32 dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .b      (b),
      .opcode (opcode),
      .out    (out)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, expv);
      end
   endtask

   // Compare the previous issue's result, then drive the next operation.
   task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] expv);
      @(negedge clk);
      if (sb_q.size() > 0) check_eq(tag_q.pop_front(), out, sb_q.pop_front());
      opcode = op;
      a      = x;
      b      = y;
      sb_q.push_back(expv);
      tag_q.push_back(tag);
   endtask

   task automatic drain();
      @(negedge clk);
      while (sb_q.size() > 0) check_eq(tag_q.pop_front(), out, sb_q.pop_front());
   endtask

   function automatic logic [63:0] int_model(input logic [4:0] op, input logic [31:0] x,
                                             input logic [31:0] y);
      logic [63:0] r;
      case (op)
         5'd0:    r = {32'd0, x + y};
         5'd1:    r = {32'd0, x - y};
         5'd2:    r = {32'd0, x & y};
         5'd3:    r = {32'd0, x | y};
         5'd4:    r = {32'd0, x ^ y};
         5'd8:    r = 64'(x) * 64'(y);
         5'd9:    r = (int'(x) < int'(y)) ? 64'd1 : 64'd0;
         5'd10:   r = {32'd0, x << y[4:0]};
         5'd11:   r = {32'd0, x >> y[4:0]};
         default: r = 64'd0;
      endcase
      return r;
   endfunction

   logic [4:0] int_ops [9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9, 5'd10, 5'd11};

   initial begin
      rst = 1'b1; a = 32'h3F800000; b = 32'h3F800000; opcode = 5'b00111;
      repeat (3) @(negedge clk);
      check_eq("reset_hold", out, 64'd0);
      rst = 1'b0;
      sb_q.push_back(64'h3F800000);
      tag_q.push_back("reset_release");

      issue("fmul_neg",    5'd7, 32'h3F800000, 32'hBF000000, 64'h00000000BF000000);
      issue("fmul_6",      5'd7, 32'h40000000, 32'h40400000, 64'h40C00000);
      issue("fadd_half",   5'd5, 32'h3F800000, 32'hBF000000, 64'h3F000000);
      issue("fsub_cancel", 5'd6, 32'h3F800000, 32'h3F800000, 64'h00000000);
      issue("fsub_round",  5'd6, 32'h3F800000, 32'h3D2AAAAB, 64'h3F755555);
      issue("fsub_neg",    5'd6, 32'h3F800000, 32'h40000000, 64'hBF800000);
      issue("fadd_tie_ev", 5'd5, 32'h4B800000, 32'h3F800000, 64'h4B800000);
      issue("fadd_tie_up", 5'd5, 32'h4B800001, 32'h3F800000, 64'h4B800002);
      issue("fadd_zero",   5'd5, 32'h3F800000, 32'h00000000, 64'h3F800000);
      issue("fadd_ovf",    5'd5, 32'h7F7FFFFF, 32'h7F7FFFFF, 64'h7F800000);
      issue("fmul_ovf",    5'd7, 32'h7F000000, 32'h40000000, 64'h7F800000);
      issue("fmul_unf",    5'd7, 32'h00800000, 32'h3F000000, 64'h00000000);
      issue("fadd_infinf", 5'd5, 32'h7F800000, 32'hFF800000, 64'h7FC00000);
      issue("fmul_inf0",   5'd7, 32'h7F800000, 32'h00000000, 64'h7FC00000);
      issue("fadd_nan",    5'd5, 32'h7F800001, 32'h3F800000, 64'h7FC00000);
      issue("fmul_denorm", 5'd7, 32'h00000001, 32'h40000000, 64'h00000000);
      issue("fmul_zsign",  5'd7, 32'hBF800000, 32'h00000000, 64'h80000000);
      issue("add_wrap",    5'd0, 32'hFFFFFFFF, 32'h00000001, 64'h0);
      issue("mul_full",    5'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
      issue("slt_neg",     5'd9, 32'hFFFFFFFF, 32'h00000000, 64'h1);
      issue("sll_31",      5'd10, 32'h00000001, 32'd31, 64'h80000000);
      issue("unused_op",   5'd31, 32'h12345678, 32'h9ABCDEF0, 64'h0);
      issue("hold_a",      5'd0, 32'h00000010, 32'h00000020, 64'h30);
      issue("hold_b",      5'd0, 32'h00000010, 32'h00000020, 64'h30);

      for (int i = 0; i < 24; i++) begin
         logic [4:0]  op;
         logic [31:0] x, y;
         op = int_ops[$urandom_range(8, 0)];
         x  = $urandom;
         y  = $urandom;
         issue("int_rand", op, x, y, int_model(op, x, y));
      end

      issue("tput_add",  5'd0, 32'h00000005, 32'h00000007, 64'h0C);
      issue("tput_fmul", 5'd7, 32'h40000000, 32'h40000000, 64'h40800000);
      issue("tput_xor",  5'd4, 32'hF0F0F0F0, 32'hFFFF0000, 64'h0F0FF0F0);
      drain();

      issue("inflight", 5'd0, 32'h00000001, 32'h00000002, 64'h3);
      @(posedge clk);
      #1;
      check_eq("inflight_pre", out, 64'h3);
      sb_q.delete();
      tag_q.delete();
      rst = 1'b1;
      #1;
      check_eq("rst_async", out, 64'd0);
      @(negedge clk);
      check_eq("rst_held", out, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("after_rst", out, 64'h3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
